// File: rtl/secuenciador_mensaje_display_pkg.sv
// Shared types for the message scroller that feeds the 7-segment display controller.
// Provides the FSM encoding, the nibble type and the circular window index helper.
package pkg_display_secuenciador;

    typedef enum logic {
        REPOSO      = 1'b0,
        DESPLAZANDO = 1'b1
    } estado_t;

    localparam int C_DIGITOS = 4;

    typedef logic [3:0] nibble_t;

    // Buffer index of digit slot 'desp' in a window starting at 'ptr', wrapping at 'largo'.
    function automatic logic [3:0] indice_ventana(
        input logic [3:0]  ptr,
        input int unsigned desp,
        input int unsigned largo
    );
        int unsigned suma;
        suma = {28'd0, ptr} + desp;
        if (suma >= largo) begin
            suma = suma - largo;
        end
        return suma[3:0];
    endfunction

endpackage

// File: rtl/secuenciador_mensaje_display_divisor_tick.sv
// Free-running prescaler: counts 0..P_DIV_TICK-1 while enabled and emits a
// one-cycle tick on the terminal count. A clear request dominates and suppresses the tick.
module divisor_tick #(
    parameter  int P_DIV_TICK = 50000000,
    localparam int W_DIV      = $clog2(P_DIV_TICK)
) (
    input  logic i_Reloj,
    input  logic i_Reset,
    input  logic i_Habilitar,
    input  logic i_Limpiar,
    output logic o_Tick
);

    localparam logic [W_DIV-1:0] C_TERMINAL = W_DIV'(P_DIV_TICK - 1);

    logic [W_DIV-1:0] cuenta;

    always_ff @(posedge i_Reloj or negedge i_Reset) begin
        if (!i_Reset) begin
            cuenta <= '0;
        end else if (i_Limpiar) begin
            cuenta <= '0;
        end else if (i_Habilitar) begin
            cuenta <= (cuenta == C_TERMINAL) ? '0 : cuenta + 1'b1;
        end
    end

    assign o_Tick = i_Habilitar && !i_Limpiar && (cuenta == C_TERMINAL);

endmodule

// File: rtl/secuenciador_mensaje_display.sv
// Scrolls a 4-digit window across a nibble message buffer, single pass or wrapping,
// and presents the window as registered digit nibbles for the 7-segment controller.
module secuenciador_mensaje_display
    import pkg_display_secuenciador::*;
#(
    parameter int P_LONG_MSG = 8,
    parameter int P_DIV_TICK = 50000000
) (
    input  logic       i_Reloj,
    input  logic       i_Reset,
    input  logic       i_Escribir,
    input  logic [3:0] i_Dir,
    input  logic [3:0] i_Dato,
    input  logic       i_Iniciar,
    input  logic       i_Detener,
    input  logic       i_Modo_Continuo,
    output logic       o_Listo,
    output logic       o_Ocupado,
    output logic       o_Fin,
    output logic [3:0] o_Datos_3,
    output logic [3:0] o_Datos_2,
    output logic [3:0] o_Datos_1,
    output logic [3:0] o_Datos_0
);

    localparam logic [3:0] C_ULTIMO_PTR = 4'(P_LONG_MSG - C_DIGITOS);
    localparam logic [3:0] C_MAX_PTR    = 4'(P_LONG_MSG - 1);
    localparam logic [4:0] C_LARGO      = 5'(P_LONG_MSG);

    estado_t    estado;
    logic       modo;
    logic [3:0] ptr;
    logic [3:0] ptr_siguiente;
    nibble_t    mem [16];
    logic       tick;
    logic       limpiar;
    logic       escritura_ok;

    // Write handshake: i_Escribir is the valid, o_Listo the ready; a write with both
    // high and i_Dir inside the message takes effect on that clock edge, else it is dropped.
    assign escritura_ok  = i_Escribir && (estado == REPOSO) && ({1'b0, i_Dir} < C_LARGO);
    assign limpiar       = (estado == REPOSO) || i_Detener;
    assign ptr_siguiente = (ptr == C_MAX_PTR) ? 4'd0 : ptr + 4'd1;
    assign o_Listo       = (estado == REPOSO);
    assign o_Ocupado     = (estado == DESPLAZANDO);

    divisor_tick #(
        .P_DIV_TICK (P_DIV_TICK)
    ) u_divisor_tick (
        .i_Reloj     (i_Reloj),
        .i_Reset     (i_Reset),
        .i_Habilitar (estado == DESPLAZANDO),
        .i_Limpiar   (limpiar),
        .o_Tick      (tick)
    );

    always_ff @(posedge i_Reloj or negedge i_Reset) begin
        if (!i_Reset) begin
            estado <= REPOSO;
            modo   <= 1'b0;
            ptr    <= 4'd0;
            o_Fin  <= 1'b0;
        end else begin
            o_Fin <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (i_Iniciar && !i_Detener) begin
                        ptr    <= 4'd0;
                        modo   <= i_Modo_Continuo;
                        estado <= DESPLAZANDO;
                    end
                end
                DESPLAZANDO: begin
                    // Stop wins over a coincident tick: the window freezes where it is.
                    if (i_Detener) begin
                        estado <= REPOSO;
                    end else if (tick) begin
                        if (modo) begin
                            ptr   <= ptr_siguiente;
                            o_Fin <= (ptr_siguiente == 4'd0);
                        end else if (ptr == C_ULTIMO_PTR) begin
                            o_Fin  <= 1'b1;
                            estado <= REPOSO;
                        end else begin
                            ptr <= ptr + 4'd1;
                        end
                    end
                end
                default: estado <= REPOSO;
            endcase
        end
    end

    always_ff @(posedge i_Reloj or negedge i_Reset) begin
        if (!i_Reset) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else if (escritura_ok) begin
            mem[i_Dir] <= i_Dato;
        end
    end

    always_ff @(posedge i_Reloj or negedge i_Reset) begin
        if (!i_Reset) begin
            o_Datos_3 <= '0;
            o_Datos_2 <= '0;
            o_Datos_1 <= '0;
            o_Datos_0 <= '0;
        end else begin
            o_Datos_3 <= mem[ptr];
            o_Datos_2 <= mem[indice_ventana(ptr, 1, P_LONG_MSG)];
            o_Datos_1 <= mem[indice_ventana(ptr, 2, P_LONG_MSG)];
            o_Datos_0 <= mem[indice_ventana(ptr, 3, P_LONG_MSG)];
        end
    end

endmodule

// File: tb/tb_secuenciador_mensaje_display.sv
// Directed bench for the message scroller with an 8-nibble buffer and a 4-cycle scroll tick.
// Inputs change 1 ns after the rising edge and outputs are sampled there as well.
module tb_secuenciador_mensaje_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       escribir;
    logic [3:0] dir;
    logic [3:0] dato;
    logic       iniciar;
    logic       detener;
    logic       modo_continuo;
    logic       listo;
    logic       ocupado;
    logic       fin;
    logic [3:0] datos_3;
    logic [3:0] datos_2;
    logic [3:0] datos_1;
    logic [3:0] datos_0;
    logic [15:0] datos;

    int n_checks = 0;
    int n_errors = 0;
    int n_fin    = 0;

    logic [15:0] exp_q[$];

    assign datos = {datos_3, datos_2, datos_1, datos_0};

    secuenciador_mensaje_display #(
        .P_LONG_MSG (8),
        .P_DIV_TICK (4)
    ) dut (
        .i_Reloj         (clk),
        .i_Reset         (rst_n),
        .i_Escribir      (escribir),
        .i_Dir           (dir),
        .i_Dato          (dato),
        .i_Iniciar       (iniciar),
        .i_Detener       (detener),
        .i_Modo_Continuo (modo_continuo),
        .o_Listo         (listo),
        .o_Ocupado       (ocupado),
        .o_Fin           (fin),
        .o_Datos_3       (datos_3),
        .o_Datos_2       (datos_2),
        .o_Datos_1       (datos_1),
        .o_Datos_0       (datos_0)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (fin === 1'b1) n_fin++;
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic escribir_nibble(input logic [3:0] d, input logic [3:0] v);
        escribir = 1'b1;
        dir      = d;
        dato     = v;
        step(1);
        escribir = 1'b0;
    endtask

    task automatic arrancar(input logic m);
        iniciar       = 1'b1;
        modo_continuo = m;
        step(1);
        iniciar = 1'b0;
    endtask

    task automatic check_window(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expected queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, datos, e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        escribir = 1'b0; dir = 4'd0; dato = 4'd0;
        iniciar = 1'b0; detener = 1'b0; modo_continuo = 1'b0;

        // reset state
        #12;
        check_eq("rst_listo", 16'(listo), 16'd1);
        check_eq("rst_ocupado", 16'(ocupado), 16'd0);
        check_eq("rst_fin", 16'(fin), 16'd0);
        check_eq("rst_datos", datos, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1);

        // load 1..8
        for (int k = 0; k < 8; k++) escribir_nibble(4'(k), 4'(k + 1));
        step(1);
        check_eq("load_window", datos, 16'h1234);

        // single pass
        arrancar(1'b0);
        check_eq("sp_ocupado", 16'(ocupado), 16'd1);
        check_eq("sp_listo", 16'(listo), 16'd0);
        exp_q = {16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678};
        step(1);
        check_window("sp_w0");
        for (int k = 1; k < 5; k++) begin
            step(4);
            check_window("sp_w");
        end
        step(2);
        check_eq("sp_fin_early", 16'(fin), 16'd0);
        step(1);
        check_eq("sp_fin", 16'(fin), 16'd1);
        check_eq("sp_end_listo", 16'(listo), 16'd1);
        check_eq("sp_end_datos", datos, 16'h5678);
        step(1);
        check_eq("sp_fin_once", 16'(fin), 16'd0);
        step(4);
        check_eq("sp_hold", datos, 16'h5678);

        // continuous
        arrancar(1'b1);
        step(1);
        check_eq("ct_w0", datos, 16'h1234);
        exp_q = {16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6781, 16'h7812, 16'h8123};
        for (int k = 1; k < 8; k++) begin
            step(4);
            check_window("ct_w");
        end
        step(2);
        check_eq("ct_fin_early", 16'(fin), 16'd0);
        step(1);
        check_eq("ct_fin_wrap", 16'(fin), 16'd1);
        check_eq("ct_still_busy", 16'(ocupado), 16'd1);
        step(1);
        check_eq("ct_wrap_window", datos, 16'h1234);
        check_eq("ct_fin_once", 16'(fin), 16'd0);
        step(4);
        check_eq("ct_w9", datos, 16'h2345);
        step(4);
        check_eq("ct_w10", datos, 16'h3456);

        // stop coincident with a tick
        step(2);
        detener = 1'b1;
        step(1);
        detener = 1'b0;
        check_eq("stop_listo", 16'(listo), 16'd1);
        check_eq("stop_ocupado", 16'(ocupado), 16'd0);
        check_eq("stop_fin", 16'(fin), 16'd0);
        step(1);
        check_eq("stop_window", datos, 16'h3456);
        check_eq("stop_fin2", 16'(fin), 16'd0);
        step(6);
        check_eq("stop_hold", datos, 16'h3456);

        // writes while busy are dropped; writes in idle land two cycles later
        arrancar(1'b0);
        escribir_nibble(4'd2, 4'd9);
        check_eq("busy_ocupado", 16'(ocupado), 16'd1);
        detener = 1'b1;
        step(1);
        detener = 1'b0;
        check_eq("busy_wr_listo", 16'(listo), 16'd1);
        check_eq("busy_wr_ignored", datos, 16'h1234);
        escribir_nibble(4'd2, 4'd9);
        check_eq("wr_latency1", 16'(datos_1), 16'd3);
        step(1);
        check_eq("wr_latency2", 16'(datos_1), 16'd9);
        escribir_nibble(4'd12, 4'hA);
        escribir_nibble(4'd8, 4'hE);
        step(1);
        check_eq("wr_out_of_range", datos, 16'h1294);

        // stop in idle, and stop+start together
        detener = 1'b1;
        step(1);
        detener = 1'b0;
        check_eq("idle_stop_listo", 16'(listo), 16'd1);
        detener = 1'b1;
        iniciar = 1'b1;
        step(1);
        detener = 1'b0;
        iniciar = 1'b0;
        check_eq("stop_start_listo", 16'(listo), 16'd1);
        check_eq("stop_start_ocupado", 16'(ocupado), 16'd0);
        step(4);
        check_eq("stop_start_window", datos, 16'h1294);

        // write and start in the same cycle
        escribir_nibble(4'd2, 4'd3);
        escribir = 1'b1; dir = 4'd0; dato = 4'hF;
        iniciar = 1'b1; modo_continuo = 1'b0;
        step(1);
        escribir = 1'b0; iniciar = 1'b0;
        check_eq("ws_ocupado", 16'(ocupado), 16'd1);
        step(1);
        check_eq("ws_first", datos, 16'hF234);
        step(4);
        check_eq("ws_second", datos, 16'h2345);
        step(12);
        check_eq("ws_last", datos, 16'h5678);
        step(3);
        check_eq("ws_fin", 16'(fin), 16'd1);
        check_eq("ws_listo", 16'(listo), 16'd1);
        step(1);

        // asynchronous reset mid-scroll
        arrancar(1'b1);
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_listo", 16'(listo), 16'd1);
        check_eq("arst_ocupado", 16'(ocupado), 16'd0);
        check_eq("arst_fin", 16'(fin), 16'd0);
        check_eq("arst_datos", datos, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        arrancar(1'b0);
        step(1);
        check_eq("arst_buffer_lost", datos, 16'h0000);
        check_eq("arst_restart", 16'(ocupado), 16'd1);
        detener = 1'b1;
        step(1);
        detener = 1'b0;

        check_eq("fin_pulse_count", 16'(n_fin), 16'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/secuenciador_mensaje_display.md
Name: secuenciador_mensaje_display

Overview:
Sequencer that drives the four digit inputs of controlador_display_7segmentos from a message buffer longer than the display. A host loads nibbles into the buffer through a write handshake. On start, the block scrolls a 4-digit window across the message at a fixed tick rate, either as a single pass or wrapping continuously. It sits directly upstream of the display controller, and its o_Datos_k outputs connect to the controller's i_Datos_k.

Parameters:
P_LONG_MSG, 8, message length in nibbles; legal range 4..16.
P_DIV_TICK, 50000000, clock cycles per scroll step; minimum 2.
W_DIV, $clog2(P_DIV_TICK), prescaler counter width; derived, not overridden.

Ports:
i_Reloj  input  1  system clock; all state changes on its rising edge.
i_Reset  input  1  asynchronous, active-low reset.
i_Escribir  input  1  write strobe; accepted only when o_Listo=1.
i_Dir  input  4  buffer address of the write.
i_Dato  input  4  nibble written.
i_Iniciar  input  1  start-scroll pulse.
i_Detener  input  1  stop-scroll pulse.
i_Modo_Continuo  input  1  1=wrap forever, 0=single pass; sampled when i_Iniciar is accepted.
o_Listo  output  1  1 in REPOSO; buffer writable and start accepted.
o_Ocupado  output  1  1 in DESPLAZANDO.
o_Fin  output  1  one-cycle pulse at end of pass.
o_Datos_3  output  4  leftmost digit nibble.
o_Datos_2  output  4  digit 2 nibble.
o_Datos_1  output  4  digit 1 nibble.
o_Datos_0  output  4  rightmost digit nibble.

Behaviour:
- Reset (i_Reset=0, asynchronous): buffer all 0, window pointer ptr=0, prescaler=0, mode latch=0, state REPOSO, o_Listo=1, o_Ocupado=0, o_Fin=0, all o_Datos_k=0.
- Display mapping: o_Datos_3=mem[ptr], o_Datos_2=mem[(ptr+1) mod L], o_Datos_1=mem[(ptr+2) mod L], o_Datos_0=mem[(ptr+3) mod L].
- o_Datos_k are registered. They reflect the ptr/mem state of the previous cycle, giving 1-cycle latency.
- REPOSO:
  - i_Escribir with i_Dir<L writes mem[i_Dir]. The displayed value updates 2 cycles after the strobe if the address is in the window.
  - i_Dir>=L is ignored silently.
  - i_Iniciar: ptr<=0, prescaler<=0, mode latched, go to DESPLAZANDO.
  - i_Escribir and i_Iniciar in the same cycle: the write completes and the scroll starts. The written nibble is visible.
- DESPLAZANDO:
  - The prescaler counts 0..P_DIV_TICK-1. At the terminal count it asserts a 1-cycle tick and wraps to 0.
  - On tick, continuous mode: ptr<=(ptr+1) mod L. o_Fin pulses in the same cycle ptr wraps to 0.
  - On tick, single pass with ptr<L-4: ptr<=ptr+1.
  - On tick, single pass with ptr==L-4: ptr holds, o_Fin pulses, go to REPOSO. The last window stays displayed.
  - Writes are ignored; o_Listo=0.
  - i_Iniciar is ignored.
- Stop: i_Detener in DESPLAZANDO goes to REPOSO, holds ptr, clears prescaler, and gives no o_Fin.
  - i_Detener has priority over a simultaneous tick.
  - i_Detener in REPOSO does nothing.
  - i_Detener and i_Iniciar together in REPOSO: start is suppressed.
- L=4 single pass: the first tick ends the pass immediately (ptr stays 0).
- Asynchronous reset mid-scroll: returns to the reset state immediately. The buffer contents are lost.
- o_Listo and o_Ocupado are decoded from the state register and are mutually exclusive.

Decomposition:
- Package pkg_display_secuenciador:
  - state encoding, 1 bit (REPOSO=0, DESPLAZANDO=1);
  - C_DIGITOS=4;
  - nibble typedef (4 bits).
- Sub-module divisor_tick: parameterised prescaler with i_Reloj, i_Reset, i_Habilitar and i_Limpiar inputs and a 1-cycle o_Tick output. It is reused by future display/refresh blocks.

Test Plan:
All scenarios use P_LONG_MSG=8 and P_DIV_TICK=4.
1. Reset -> o_Listo=1, o_Ocupado=0, o_Fin=0, all o_Datos_k=0; an assertion mid-scroll clears everything asynchronously, without waiting for a clock edge.
2. Load mem=1,2,3,4,5,6,7,8, pulse i_Iniciar with i_Modo_Continuo=0 -> window 1234, 2345, ... 5678, advancing every 4 cycles. o_Fin pulses once at the tick while 5678 is shown, then o_Listo=1 and 5678 is held.
3. Same data, i_Modo_Continuo=1 -> after 5678 comes 6781, 7812, 8123, 1234. o_Fin pulses when ptr returns to 0, and scrolling continues.
4. i_Detener asserted on the same cycle as a tick, while 3456 is shown -> state REPOSO, 3456 held, no o_Fin; writes are accepted again.
5. i_Escribir i_Dir=2, i_Dato=9 while o_Ocupado=1 -> mem unchanged. The same write in REPOSO with ptr=0 -> o_Datos_1=9 two cycles later. i_Dir=12 -> ignored.
6. Simultaneous i_Escribir (i_Dir=0, i_Dato=F) and i_Iniciar -> scrolling starts with first window F234.
